mini_cpu_sequencer: RTL and testbench

- Program sequencer for the MiniCPU datapath.
- Holds a small program memory of {opcode, immediate} words, loaded through a write port while idle.
- On a start pulse, steps through the program and drives the 4-bit opcode into the instruction decoder and the 8-bit immediate onto the datapath input bus, one instruction at a time.
- Stops on a HALT opcode, at the programmed length, or on abort.

---
 rtl/mini_cpu_pkg.sv | 26 ++
 rtl/mini_cpu_prog_ram.sv | 26 ++
 rtl/mini_cpu_sequencer.sv | 96 +++++++++
 tb/tb_mini_cpu_sequencer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mini_cpu_pkg.sv
// Shared MiniCPU definitions: decoder opcodes, sequencer control opcodes
// and the sequencer state encoding.
package mini_cpu_pkg;

   localparam logic [3:0] OP_CLR        = 4'd0;
   localparam logic [3:0] OP_MOV_R1     = 4'd1;
   localparam logic [3:0] OP_MOV_R2     = 4'd2;
   localparam logic [3:0] OP_MOV_OUT_R2 = 4'd3;
   localparam logic [3:0] OP_ADD        = 4'd4;
   localparam logic [3:0] OP_SHL        = 4'd5;
   localparam logic [3:0] OP_SHR        = 4'd6;
   localparam logic [3:0] OP_AND        = 4'd7;
   localparam logic [3:0] OP_ORR        = 4'd8;
   localparam logic [3:0] OP_CMP        = 4'd9;

   localparam logic [3:0] NOP_OP  = 4'hF;
   localparam logic [3:0] HALT_OP = 4'hE;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

endpackage

// File: rtl/mini_cpu_prog_ram.sv
// Program store for the sequencer: one synchronous write port and one
// synchronous, enabled read port.
module mini_cpu_prog_ram #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int W     = 12
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];

   // NOTE: no reset here on purpose; a resettable array cannot map onto RAM
   // macros, and the program survives a sequencer reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/mini_cpu_sequencer.sv
// MiniCPU program sequencer: fetches {opcode, immediate} words from the
// program RAM and presents one instruction at a time to the decoder.
module mini_cpu_sequencer
   import mini_cpu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [3:0]    wr_op,
   input  logic [7:0]    wr_imm,
   input  logic [AW:0]   prog_len,
   input  logic          start,
   input  logic          abort,
   input  logic          stall,
   output logic [3:0]    instruction,
   output logic [7:0]    imm,
   output logic          instr_valid,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          done
);

   seq_state_t    state, state_nxt;
   logic [AW:0]   len;
   logic [AW:0]   len_clamped;
   logic [11:0]   rd_data;
   logic [3:0]    rd_op;
   logic [7:0]    rd_imm;
   logic          is_halt;
   logic          is_last;
   logic          advance;

   mini_cpu_prog_ram #(.DEPTH(DEPTH), .AW(AW), .W(12)) u_ram (
      .clk     (clk),
      .wr_en   (wr_en && state == ST_IDLE),
      .wr_addr (wr_addr),
      .wr_data ({wr_op, wr_imm}),
      .rd_en   (state == ST_FETCH),
      .rd_addr (pc),
      .rd_data (rd_data)
   );

   assign rd_op       = rd_data[11:8];
   assign rd_imm      = rd_data[7:0];
   assign is_halt     = (rd_op == HALT_OP);
   assign is_last     = (({1'b0, pc} + (AW+1)'(1)) == len);
   assign len_clamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
   assign advance     = (state == ST_EXEC) && !abort && !is_halt && !stall && !is_last;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (start) state_nxt = (prog_len == '0) ? ST_DONE : ST_FETCH;
         ST_FETCH: state_nxt = ST_EXEC;
         ST_EXEC: begin
            if (is_halt)     state_nxt = ST_DONE;
            else if (!stall) state_nxt = is_last ? ST_DONE : ST_FETCH;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      // Abort overrides every other transition once a run is in progress.
      if (abort && state != ST_IDLE) state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc  <= '0;
         len <= '0;
      end else if (state == ST_IDLE && start) begin
         pc  <= '0;
         len <= len_clamped;
      end else if (advance) begin
         pc  <= pc + AW'(1);
      end
   end

   // Anything not issued shows NOP so the decoder never acts on stale data.
   always_comb begin
      instr_valid = (state == ST_EXEC) && !is_halt && !abort;
      instruction = instr_valid ? rd_op : NOP_OP;
      imm         = instr_valid ? rd_imm : 8'h00;
      busy        = (state != ST_IDLE);
      done        = (state == ST_DONE) && !abort;
   end

endmodule

// File: tb/tb_mini_cpu_sequencer.sv
// Directed bench for mini_cpu_sequencer: every issued instruction is popped
// from an expected-instruction queue and compared as it appears.
module tb_mini_cpu_sequencer;

   typedef struct packed {
      logic [3:0] op;
      logic [7:0] imm;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [3:0] wr_op = '0;
   logic [7:0] wr_imm = '0;
   logic [4:0] prog_len = '0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       stall = 1'b0;
   logic [3:0] instruction;
   logic [7:0] imm;
   logic       instr_valid;
   logic [3:0] pc;
   logic       busy;
   logic       done;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   valid_cnt = 0;
   int   done_cnt  = 0;

   mini_cpu_sequencer #(.DEPTH(16), .AW(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_op       (wr_op),
      .wr_imm      (wr_imm),
      .prog_len    (prog_len),
      .start       (start),
      .abort       (abort),
      .stall       (stall),
      .instruction (instruction),
      .imm         (imm),
      .instr_valid (instr_valid),
      .pc          (pc),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; outputs are sampled on the falling edge and issued
   // instructions are matched against the scoreboard.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (done === 1'b1) done_cnt++;
      if (instr_valid === 1'b1) begin
         valid_cnt++;
         if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            check("sb_op", 32'(instruction), 32'(e.op));
            check("sb_imm", 32'(imm), 32'(e.imm));
         end
      end else if (rst === 1'b0) begin
         check("nop_when_invalid", 32'(instruction), 32'hF);
      end
   endtask

   task automatic write_word(input logic [3:0] a, input logic [3:0] op, input logic [7:0] im);
      wr_en = 1'b1; wr_addr = a; wr_op = op; wr_imm = im;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic push(input logic [3:0] op, input logic [7:0] im);
      exp_t e;
      e.op = op;
      e.imm = im;
      sb.push_back(e);
   endtask

   task automatic start_run(input logic [4:0] len);
      valid_cnt = 0;
      done_cnt  = 0;
      cyc       = 0;
      prog_len  = len;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int exp_cyc);
      while (done !== 1'b1 && cyc < 80) tick();
      check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
      tick();
      check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
      check({tag, "_idle_after_done"}, 32'(busy), 32'd0);
      check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      tick();
      tick();
      check("rst_instruction", 32'(instruction), 32'hF);
      check("rst_imm", 32'(imm), 32'h0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      tick();

      // Basic program terminated by HALT before the programmed length
      write_word(4'd0, 4'h1, 8'h05);
      write_word(4'd1, 4'h2, 8'h03);
      write_word(4'd2, 4'h4, 8'h00);
      write_word(4'd3, 4'hE, 8'h00);
      push(4'h1, 8'h05); push(4'h2, 8'h03); push(4'h4, 8'h00);
      start_run(5'd8);
      check("halt_busy_fetch", 32'(busy), 32'd1);
      check("halt_valid_fetch", 32'(instr_valid), 32'd0);
      tick();
      check("halt_first_valid_c2", 32'(instr_valid), 32'd1);
      wait_done("halt", 9);
      check("halt_valid_count", 32'(valid_cnt), 32'd3);

      // Zero-length program goes straight to DONE
      start_run(5'd0);
      check("len0_done_c1", 32'(done), 32'd1);
      tick();
      check("len0_busy", 32'(busy), 32'd0);
      check("len0_no_valid", 32'(valid_cnt), 32'd0);

      // Stall held for three cycles on the second instruction
      write_word(4'd0, 4'h3, 8'h11);
      write_word(4'd1, 4'h5, 8'h22);
      write_word(4'd2, 4'h6, 8'h33);
      push(4'h3, 8'h11);
      repeat (4) push(4'h5, 8'h22);
      push(4'h6, 8'h33);
      start_run(5'd3);
      tick(); tick(); tick();
      stall = 1'b1;
      check("stall_pc_c4", 32'(pc), 32'd1);
      tick();
      check("stall_pc_c5", 32'(pc), 32'd1);
      check("stall_valid_c5", 32'(instr_valid), 32'd1);
      tick(); tick();
      check("stall_pc_c7", 32'(pc), 32'd1);
      stall = 1'b0;
      wait_done("stall", 10);
      check("stall_valid_count", 32'(valid_cnt), 32'd6);

      // Abort during the fetch of the second word
      push(4'h3, 8'h11);
      start_run(5'd3);
      tick(); tick();
      check("abort_pc_fetch", 32'(pc), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(instr_valid), 32'd0);
      tick(); tick();
      check("abort_no_done", 32'(done_cnt), 32'd0);
      check("abort_sb_drained", 32'(sb.size()), 32'd0);
      push(4'h3, 8'h11); push(4'h5, 8'h22); push(4'h6, 8'h33);
      start_run(5'd3);
      check("rerun_pc0", 32'(pc), 32'd0);
      wait_done("rerun", 7);

      // Write and start while busy are both ignored
      push(4'h3, 8'h11); push(4'h5, 8'h22); push(4'h6, 8'h33);
      start_run(5'd3);
      tick();
      wr_en = 1'b1; wr_addr = 4'd1; wr_op = 4'h9; wr_imm = 8'h99; start = 1'b1;
      tick();
      wr_en = 1'b0; start = 1'b0;
      check("busy_start_pc", 32'(pc), 32'd1);
      check("busy_start_busy", 32'(busy), 32'd1);
      wait_done("busy_ign", 7);
      push(4'h3, 8'h11); push(4'h5, 8'h22); push(4'h6, 8'h33);
      start_run(5'd3);
      wait_done("mem_kept", 7);

      // Full-depth program with an over-range length, then reset mid-run
      for (int i = 0; i < 16; i++) write_word(4'(i), 4'h7, 8'(i * 3));
      for (int i = 0; i < 16; i++) push(4'h7, 8'(i * 3));
      start_run(5'd20);
      while (done !== 1'b1 && cyc < 80) tick();
      check("full_done_cycle", 32'(cyc), 32'd33);
      check("full_pc_end", 32'(pc), 32'd15);
      check("full_valid_count", 32'(valid_cnt), 32'd16);
      tick();
      check("full_pc_kept", 32'(pc), 32'd15);
      check("full_busy", 32'(busy), 32'd0);

      push(4'h7, 8'd0); push(4'h7, 8'd3);
      start_run(5'd16);
      tick(); tick(); tick(); tick();
      rst = 1'b1;
      start = 1'b1;
      tick();
      rst = 1'b0;
      start = 1'b0;
      check("mid_rst_instruction", 32'(instruction), 32'hF);
      check("mid_rst_imm", 32'(imm), 32'h0);
      check("mid_rst_valid", 32'(instr_valid), 32'd0);
      check("mid_rst_pc", 32'(pc), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_sb", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
